// File: rtl/manual_digit_entry_if.sv
// Bus between the switch/button front end and the digit entry block.
// The master drives the switch and button inputs; the slave returns the buffer and entry results.
interface manual_digit_entry_if #(
   parameter int NUM_DIGITS = 4
);
   localparam int CW = $clog2(NUM_DIGITS + 1);

   logic [3:0]              d_manual;
   logic                    sw_enable;
   logic                    btn_enter;
   logic                    btn_clear;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [CW-1:0]           digit_count;
   logic                    digit_strobe;
   logic                    overflow;
   logic                    entry_valid;
   logic [4*NUM_DIGITS-1:0] entry_value;
   logic [CW-1:0]           entry_len;
   logic                    busy;

   modport master (
      output d_manual, sw_enable, btn_enter, btn_clear,
      input  digits, digit_count, digit_strobe, overflow,
      input  entry_valid, entry_value, entry_len, busy
   );

   modport slave (
      input  d_manual, sw_enable, btn_enter, btn_clear,
      output digits, digit_count, digit_strobe, overflow,
      output entry_valid, entry_value, entry_len, busy
   );
endinterface

// File: rtl/manual_digit_entry.sv
// Debounces presses from the switch priority encoder and shifts each accepted digit into a
// calculator-style BCD buffer; enter hands the finished entry downstream, clear discards it.
module manual_digit_entry #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 50000
) (
   input logic                   clk,
   input logic                   rst_n,
   manual_digit_entry_if.slave   bus
);
   localparam int CW    = $clog2(NUM_DIGITS + 1);
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int DW    = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
   localparam logic [CW-1:0]    CNT_FULL = CW'(NUM_DIGITS);
   localparam logic [CW-1:0]    CW_ZERO  = {CW{1'b0}};
   localparam logic [DW-1:0]    DW_ZERO  = {DW{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_HELD     = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_cand;
   logic             r_busy;
   logic [DW-1:0]    r_digits;
   logic [CW-1:0]    r_count;
   logic             r_strobe;
   logic             r_overflow;
   logic             r_entry_valid;
   logic [DW-1:0]    r_entry_value;
   logic [CW-1:0]    r_entry_len;

   logic             w_match;
   logic             w_commit;
   logic             w_enter;
   logic [DW-1:0]    w_base_digits;
   logic [CW-1:0]    w_base_count;
   logic [DW+3:0]    w_shifted;
   logic             w_room;

   // Commit fires on the edge that samples the last required matching level.
   always_comb begin
      w_match  = bus.sw_enable && (bus.d_manual == r_cand);
      w_commit = (r_state == S_DEBOUNCE) && w_match && (r_cnt == CNT_LAST);
      w_enter  = bus.btn_enter && (r_count != CW_ZERO);
      if (w_enter) begin
         w_base_digits = DW_ZERO;
         w_base_count  = CW_ZERO;
      end else begin
         w_base_digits = r_digits;
         w_base_count  = r_count;
      end
      w_shifted = {w_base_digits, r_cand};
      w_room    = (w_base_count < CNT_FULL);
   end

   // Press/release debounce state machine; busy tracks the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= CNT_ZERO;
         r_cand  <= 4'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.sw_enable) begin
                  r_state <= S_DEBOUNCE;
                  r_cand  <= bus.d_manual;
                  r_cnt   <= CNT_ONE;
                  r_busy  <= 1'b1;
               end else begin
                  r_cnt  <= CNT_ZERO;
                  r_busy <= 1'b0;
               end
            end
            S_DEBOUNCE: begin
               if (!w_match) begin
                  r_state <= S_IDLE;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_cnt != CNT_MAX) begin
                     r_cnt <= r_cnt + CNT_ONE;
                  end
                  if (w_commit) begin
                     r_state <= S_HELD;
                  end
               end
            end
            S_HELD: begin
               // Digit changes while held are ignored until a full release.
               if (!bus.sw_enable) begin
                  r_state <= S_RELEASE;
                  r_cnt   <= CNT_ONE;
               end
            end
            S_RELEASE: begin
               if (bus.sw_enable) begin
                  r_state <= S_HELD;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b0;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= CNT_ZERO;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Entry buffer: clear beats enter and commit; a commit lands in the buffer enter just emptied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digits      <= DW_ZERO;
         r_count       <= CW_ZERO;
         r_strobe      <= 1'b0;
         r_overflow    <= 1'b0;
         r_entry_valid <= 1'b0;
         r_entry_value <= DW_ZERO;
         r_entry_len   <= CW_ZERO;
      end else begin
         r_strobe      <= 1'b0;
         r_overflow    <= 1'b0;
         r_entry_valid <= 1'b0;
         if (bus.btn_clear) begin
            r_digits <= DW_ZERO;
            r_count  <= CW_ZERO;
         end else begin
            if (w_enter) begin
               r_entry_value <= r_digits;
               r_entry_len   <= r_count;
               r_entry_valid <= 1'b1;
            end
            if (w_commit && w_room) begin
               r_digits <= w_shifted[DW-1:0];
               r_count  <= w_base_count + CW'(1);
               r_strobe <= 1'b1;
            end else begin
               r_digits <= w_base_digits;
               r_count  <= w_base_count;
               if (w_commit) begin
                  r_overflow <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.digits       = r_digits;
   assign bus.digit_count  = r_count;
   assign bus.digit_strobe = r_strobe;
   assign bus.overflow     = r_overflow;
   assign bus.entry_valid  = r_entry_valid;
   assign bus.entry_value  = r_entry_value;
   assign bus.entry_len    = r_entry_len;
   assign bus.busy         = r_busy;
endmodule

// File: tb/tb_manual_digit_entry.sv
// Directed bench for manual_digit_entry with a short debounce window (4 cycles) and 4-digit buffer.
module tb_manual_digit_entry;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n_strobe;
   int   n_ovf;
   int   base_s;
   int   base_o;

   manual_digit_entry_if #(.NUM_DIGITS(4)) bus ();

   manual_digit_entry #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tally pulses as they are seen on each rising edge.
   always @(posedge clk) begin
      if (bus.digit_strobe) n_strobe <= n_strobe + 1;
      if (bus.overflow)     n_ovf    <= n_ovf + 1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] d, input int n_high, input int n_low);
      bus.d_manual  = d;
      bus.sw_enable = 1'b1;
      step(n_high);
      bus.sw_enable = 1'b0;
      step(n_low);
   endtask

   task automatic pulse_clear;
      bus.btn_clear = 1'b1;
      step(1);
      bus.btn_clear = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; n_strobe = 0; n_ovf = 0;
      rst_n = 1'b0;
      bus.d_manual = 4'd0; bus.sw_enable = 1'b0;
      bus.btn_enter = 1'b0; bus.btn_clear = 1'b0;
      step(2);
      chk("rst_digits", 32'(bus.digits), 32'h0);
      chk("rst_count", 32'(bus.digit_count), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_evalid", 32'(bus.entry_valid), 32'h0);
      chk("rst_evalue", 32'(bus.entry_value), 32'h0);
      rst_n = 1'b1;
      step(1);

      // Single press of 7
      base_s = n_strobe;
      bus.d_manual = 4'd7; bus.sw_enable = 1'b1;
      step(1);
      chk("p7_busy", 32'(bus.busy), 32'h1);
      step(2);
      chk("p7_nostrobe_early", 32'(bus.digit_strobe), 32'h0);
      step(1);
      chk("p7_strobe", 32'(bus.digit_strobe), 32'h1);
      chk("p7_digits", 32'(bus.digits), 32'h0007);
      chk("p7_count", 32'(bus.digit_count), 32'h1);
      bus.sw_enable = 1'b0;
      step(3);
      chk("p7_busy_release", 32'(bus.busy), 32'h1);
      step(1);
      chk("p7_idle", 32'(bus.busy), 32'h0);
      chk("p7_one_strobe", 32'(n_strobe - base_s), 32'h1);
      pulse_clear();
      chk("clr_count", 32'(bus.digit_count), 32'h0);
      chk("clr_digits", 32'(bus.digits), 32'h0);

      // Bouncing switch never settles
      base_s = n_strobe;
      bus.d_manual = 4'd3;
      for (int i = 0; i < 5; i++) begin
         bus.sw_enable = 1'b1; step(2);
         bus.sw_enable = 1'b0; step(2);
      end
      chk("bounce_strobes", 32'(n_strobe - base_s), 32'h0);
      chk("bounce_count", 32'(bus.digit_count), 32'h0);
      chk("bounce_idle", 32'(bus.busy), 32'h0);

      // Five digits into a four-digit buffer
      base_s = n_strobe; base_o = n_ovf;
      press(4'd1, 4, 4); press(4'd2, 4, 4); press(4'd3, 4, 4); press(4'd4, 4, 4);
      chk("fill_ovf_none", 32'(n_ovf - base_o), 32'h0);
      press(4'd5, 4, 4);
      chk("fill_digits", 32'(bus.digits), 32'h1234);
      chk("fill_count", 32'(bus.digit_count), 32'h4);
      chk("fill_strobes", 32'(n_strobe - base_s), 32'h4);
      chk("fill_ovf", 32'(n_ovf - base_o), 32'h1);
      bus.btn_enter = 1'b1; step(1); bus.btn_enter = 1'b0;
      chk("ent_valid", 32'(bus.entry_valid), 32'h1);
      chk("ent_value", 32'(bus.entry_value), 32'h1234);
      chk("ent_len", 32'(bus.entry_len), 32'h4);
      chk("ent_digits", 32'(bus.digits), 32'h0);
      chk("ent_count", 32'(bus.digit_count), 32'h0);
      step(1);
      chk("ent_valid_pulse", 32'(bus.entry_valid), 32'h0);
      chk("ent_value_hold", 32'(bus.entry_value), 32'h1234);

      // Enter on an empty buffer is ignored
      bus.btn_enter = 1'b1; step(1); bus.btn_enter = 1'b0;
      chk("empty_ent_valid", 32'(bus.entry_valid), 32'h0);
      chk("empty_ent_len", 32'(bus.entry_len), 32'h4);

      // Held 9 changed to 2, then a release bounce
      base_s = n_strobe;
      bus.d_manual = 4'd9; bus.sw_enable = 1'b1;
      step(4);
      bus.d_manual = 4'd2;
      step(6);
      bus.sw_enable = 1'b0; step(2);
      bus.sw_enable = 1'b1; step(1);
      chk("held_busy", 32'(bus.busy), 32'h1);
      bus.sw_enable = 1'b0; step(4);
      chk("held_one_strobe", 32'(n_strobe - base_s), 32'h1);
      chk("held_digits", 32'(bus.digits), 32'h0009);
      chk("held_count", 32'(bus.digit_count), 32'h1);
      chk("held_idle", 32'(bus.busy), 32'h0);
      pulse_clear();

      // Clear and enter on the same edge
      press(4'd5, 4, 4); press(4'd6, 4, 4);
      chk("ce_digits_pre", 32'(bus.digits), 32'h0056);
      bus.btn_clear = 1'b1; bus.btn_enter = 1'b1; step(1);
      bus.btn_clear = 1'b0; bus.btn_enter = 1'b0;
      chk("ce_no_valid", 32'(bus.entry_valid), 32'h0);
      chk("ce_count", 32'(bus.digit_count), 32'h0);
      chk("ce_value_hold", 32'(bus.entry_value), 32'h1234);

      // Enter on the commit edge of 8
      press(4'd1, 4, 4);
      bus.d_manual = 4'd8; bus.sw_enable = 1'b1;
      step(3);
      bus.btn_enter = 1'b1; step(1); bus.btn_enter = 1'b0;
      chk("ec_valid", 32'(bus.entry_valid), 32'h1);
      chk("ec_value", 32'(bus.entry_value), 32'h0001);
      chk("ec_len", 32'(bus.entry_len), 32'h1);
      chk("ec_digits", 32'(bus.digits), 32'h0008);
      chk("ec_count", 32'(bus.digit_count), 32'h1);
      chk("ec_strobe", 32'(bus.digit_strobe), 32'h1);
      bus.sw_enable = 1'b0; step(4);

      // Clear on the commit edge of 4
      bus.d_manual = 4'd4; bus.sw_enable = 1'b1;
      step(3);
      bus.btn_clear = 1'b1; step(1); bus.btn_clear = 1'b0;
      chk("cc_count", 32'(bus.digit_count), 32'h0);
      chk("cc_strobe", 32'(bus.digit_strobe), 32'h0);
      chk("cc_ovf", 32'(bus.overflow), 32'h0);
      bus.sw_enable = 1'b0; step(4);

      // Reset in the middle of debounce
      base_s = n_strobe;
      bus.d_manual = 4'd6; bus.sw_enable = 1'b1;
      step(2);
      rst_n = 1'b0; #1;
      chk("rd_busy", 32'(bus.busy), 32'h0);
      bus.sw_enable = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(6);
      chk("rd_no_strobe", 32'(n_strobe - base_s), 32'h0);

      // Reset while held
      bus.d_manual = 4'd2; bus.sw_enable = 1'b1;
      step(4);
      chk("rh_digits_pre", 32'(bus.digits), 32'h0002);
      step(2);
      base_s = n_strobe;
      rst_n = 1'b0; #1;
      chk("rh_digits", 32'(bus.digits), 32'h0);
      chk("rh_count", 32'(bus.digit_count), 32'h0);
      chk("rh_busy", 32'(bus.busy), 32'h0);
      chk("rh_evalue", 32'(bus.entry_value), 32'h0);
      chk("rh_elen", 32'(bus.entry_len), 32'h0);
      bus.sw_enable = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(6);
      chk("rh_no_strobe", 32'(n_strobe - base_s), 32'h0);
      chk("rh_count_after", 32'(bus.digit_count), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
